// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a UART byte stream into the
// instruction RAM and releases the CPU once the length/XOR-checksum frame verifies.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  // Word counts are compared in 17 bits so a full 2^ADDR_WIDTH image is representable.
  localparam int          CW        = 17;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            xor_q, xor_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [15:0]           len_new;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN_HI;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      xor_q      <= xor_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign len_new = {len_q[15:8], rx_data};

  always_comb begin
    // NOTE: every variable gets a hold/default value first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    xor_d      = xor_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (rx_valid) begin
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = rx_data;
          xor_d       = xor_q ^ rx_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_new;
          xor_d = xor_q ^ rx_data;
          if ({1'b0, len_new} > MAX_WORDS) state_d = S_ERR;
          else if (len_new == 16'd0)       state_d = S_CSUM;
          else                             state_d = S_DATA;
        end
        S_DATA: begin
          xor_d      = xor_q ^ rx_data;
          asm_d      = {asm_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
            wr_data_d  = {asm_q, rx_data};
            word_idx_d = word_idx_q + 1'b1;
            if (CW'(word_idx_q) + CW'(1) == {1'b0, len_q}) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
        end
        default: ;  // S_DONE / S_ERR hold until reset
      endcase
    end
  end

  always_comb begin
    cpu_hold   = (state_q != S_DONE);
    load_done  = (state_q == S_DONE);
    load_error = (state_q == S_ERR);
    wr_en      = wr_en_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are scored against a frame-level
// model that derives expected writes and status from the byte stream alone.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold, load_done, load_error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            bidx;
  } wr_t;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [7:0]    byte_q[$];
  int            byte_cyc[$];
  wr_t           exp_wr[$];
  wr_t           mon_w;
  int            n_acc = 0;
  bit            mon_en = 1'b0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int frame_words();
    return int'(byte_q[0]) * 256 + int'(byte_q[1]);
  endfunction

  // Expected {cpu_hold, load_done, load_error} once the first k bytes are in.
  function automatic logic [2:0] exp_status(int k);
    int n;
    logic [7:0] x;
    if (k < 2) return 3'b100;
    n = frame_words();
    if (n > (1 << AW)) return 3'b101;
    if (k < 4 * n + 3) return 3'b100;
    x = '0;
    for (int i = 0; i < 4 * n + 2; i++) x ^= byte_q[i];
    return (x == byte_q[4 * n + 2]) ? 3'b010 : 3'b101;
  endfunction

  function automatic logic [7:0] xor_all();
    logic [7:0] x = '0;
    foreach (byte_q[i]) x ^= byte_q[i];
    return x;
  endfunction

  function automatic void build_writes();
    int  n;
    int  b;
    wr_t w;
    exp_wr.delete();
    if (byte_q.size() < 2) return;
    n = frame_words();
    if (n > (1 << AW)) return;
    for (int i = 0; i < n; i++) begin
      b = 2 + 4 * i;
      if (b + 3 < byte_q.size()) begin
        w.addr = AW'(i);
        w.data = {byte_q[b], byte_q[b+1], byte_q[b+2], byte_q[b+3]};
        w.bidx = b + 3;
        exp_wr.push_back(w);
      end
    end
  endfunction

  // Samples 1 time unit after each rising edge, away from the drive edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      while (n_acc < byte_cyc.size() && byte_cyc[n_acc] < cyc) n_acc++;
      check("status", 32'({cpu_hold, load_done, load_error}), 32'(exp_status(n_acc)));
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          check("wr_spurious", 32'(wr_en), 32'd0);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_w.addr));
          check("wr_data", wr_data, mon_w.data);
          check("wr_latency", cyc,
                (mon_w.bidx < byte_cyc.size()) ? byte_cyc[mon_w.bidx] + 1 : -1);
          last_addr = mon_w.addr;
          last_data = mon_w.data;
        end
      end else begin
        check("wr_addr_hold", 32'(wr_addr), 32'(last_addr));
        check("wr_data_hold", wr_data, last_data);
        if (exp_wr.size() > 0 && exp_wr[0].bidx < byte_cyc.size() &&
            cyc > byte_cyc[exp_wr[0].bidx] + 1) begin
          check("wr_missing", 32'(wr_en), 32'd1);
          void'(exp_wr.pop_front());
        end
      end
    end
  end

  task automatic do_reset(bit with_byte);
    @(negedge clk);
    mon_en   = 1'b0;
    reset    = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'h00;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_status", 32'({cpu_hold, load_done, load_error}), 32'b100);
    byte_q.delete();
    byte_cyc.delete();
    exp_wr.delete();
    n_acc     = 0;
    last_addr = '0;
    last_data = '0;
    mon_en    = 1'b1;
  endtask

  // Sends every not-yet-sent byte of byte_q; gap = idle cycles between bytes.
  task automatic drive(int gap);
    int idx;
    while (byte_cyc.size() < byte_q.size()) begin
      idx = byte_cyc.size();
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = byte_q[idx];
      byte_cyc.push_back(cyc);
      if (gap > 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic finish_stream();
    repeat (4) @(negedge clk);
    check("wr_pending", exp_wr.size(), 32'd0);
  endtask

  task automatic load_example(bit good);
    byte_q = '{8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00,
               8'h00, 8'h27, 8'h08, 8'h00, 8'h00, 8'h8E};
    byte_q.push_back(good ? xor_all() : xor_all() ^ 8'h01);
    build_writes();
  endtask

  task automatic rand_frame();
    int n;
    int nbytes;
    int mode = $urandom_range(0, 9);
    do_reset(mode == 0);
    n = (mode == 1) ? $urandom_range(257, 65535) : $urandom_range(0, 10);
    byte_q.push_back(8'(n >> 8));
    byte_q.push_back(8'(n));
    nbytes = (n > 256) ? $urandom_range(0, 8) : 4 * n;
    for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
    if (n <= 256)
      byte_q.push_back(($urandom_range(0, 3) != 0) ? xor_all()
                                                  : xor_all() ^ 8'($urandom_range(1, 255)));
    build_writes();
    drive($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) begin
      byte_q.push_back(8'($urandom));
      drive(0);
    end
    finish_stream();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset(1'b0);

    // Example image, slow byte rate
    load_example(1'b1);
    drive(15);
    finish_stream();

    // Same image, back-to-back bytes
    do_reset(1'b0);
    load_example(1'b1);
    drive(0);
    finish_stream();

    // Bad checksum, then a trailing byte that must be ignored
    do_reset(1'b0);
    load_example(1'b0);
    drive(1);
    finish_stream();
    byte_q.push_back(8'h81);
    drive(0);
    finish_stream();

    // Empty image
    do_reset(1'b0);
    byte_q = '{8'h00, 8'h00, 8'h00};
    build_writes();
    drive(2);
    finish_stream();

    // Oversize count followed by data that must not be written
    do_reset(1'b0);
    byte_q = '{8'h01, 8'h01};
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    build_writes();
    drive(0);
    finish_stream();

    // Full-capacity image: last write lands on the top address
    do_reset(1'b0);
    byte_q = '{8'h01, 8'h00};
    for (int i = 0; i < 4 * 256; i++) byte_q.push_back(8'($urandom));
    byte_q.push_back(xor_all());
    build_writes();
    drive(0);
    finish_stream();

    // Reset mid-load with a byte presented during reset
    do_reset(1'b0);
    byte_q = '{8'h00, 8'h02, 8'h12, 8'h34};
    build_writes();
    drive(1);
    do_reset(1'b1);
    byte_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    byte_q.push_back(xor_all());
    build_writes();
    drive(1);
    finish_stream();

    for (int i = 0; i < 40; i++) rand_frame();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
